// File: rtl/main_config.sv
// Application-wide configuration shared by the audio cores.
// Latency: n/a (constants only).
// Backpressure: n/a.
package main_config;

    localparam int DATA_WIDTH     = 24;   // signed audio sample width
    localparam int KNOB_WIDTH     = 8;    // unsigned control value width
    localparam int TREM_PHASE_W   = 24;   // tremolo LFO phase accumulator width
    localparam int TREM_INC_SHIFT = 4;    // phase step = (speed + 1) << TREM_INC_SHIFT
    localparam bit TREMOLO_EN     = 1'b1; // application core instantiates tremolo_core when set

endpackage

// File: rtl/tremolo_core_pkg.sv
// Shared types and helpers for the tremolo datapath (gain and triangle folding).
// Latency: n/a (pure functions).
// Backpressure: n/a.
package tremolo_core_pkg;

    localparam int LFO_W  = 8;   // triangle LFO resolution
    localparam int GAIN_W = 9;   // gain spans 2..256, needs 9 bits
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    // Fold the top phase bits into a triangle: rising in the lower half of
    // the cycle, mirrored in the upper half.
    function automatic logic [LFO_W-1:0] fold_tri(input logic msb, input logic [LFO_W-1:0] seg);
        return msb ? ~seg : seg;
    endfunction

    // gain = 256 - (depth * tri) >> 8; bypass pins it to unity.
    function automatic logic [GAIN_W-1:0] calc_gain(
        input logic [LFO_W-1:0] depth,
        input logic [LFO_W-1:0] tri_val,
        input logic             bypass
    );
        logic [2*LFO_W-1:0] atten;
        atten = {{LFO_W{1'b0}}, depth} * {{LFO_W{1'b0}}, tri_val};
        if (bypass) begin
            return GAIN_UNITY;
        end
        return GAIN_UNITY - {1'b0, atten[2*LFO_W-1:LFO_W]};
    endfunction

endpackage

// File: rtl/tremolo_core_if.sv
// Sample stream + control bundle between the application core and tremolo_core.
// Latency: n/a (wires only).
// Backpressure: none; sample_valid_i is a strobe with no ready.
// master: drives sample_valid_i/sample_i/speed_i/depth_i/bypass_i, reads outputs.
// slave : the tremolo core, drives sample_valid_o/sample_o/lfo_o.
interface tremolo_core_if #(
    parameter int DATA_WIDTH = main_config::DATA_WIDTH,
    parameter int KNOB_WIDTH = main_config::KNOB_WIDTH
) ();

    logic                         sample_valid_i;
    logic signed [DATA_WIDTH-1:0] sample_i;
    logic        [KNOB_WIDTH-1:0] speed_i;
    logic        [KNOB_WIDTH-1:0] depth_i;
    logic                         bypass_i;
    logic                         sample_valid_o;
    logic signed [DATA_WIDTH-1:0] sample_o;
    logic        [7:0]            lfo_o;

    modport master (
        output sample_valid_i, sample_i, speed_i, depth_i, bypass_i,
        input  sample_valid_o, sample_o, lfo_o
    );

    modport slave (
        input  sample_valid_i, sample_i, speed_i, depth_i, bypass_i,
        output sample_valid_o, sample_o, lfo_o
    );

endinterface

// File: rtl/trem_lfo.sv
// Triangle LFO: phase accumulator stepped once per input sample, folded to 8 bits.
// Latency: tri_val is combinational from the current phase; lfo is tri_val one cycle later.
// Backpressure: none; advances on every advance strobe.
// Ports: clk_i/rstn_i, advance (sample strobe), speed (rate setting), tri_val (pre-increment
// triangle for the gain of the sample being accepted), lfo (registered LED value).
module trem_lfo
    import tremolo_core_pkg::*;
#(
    parameter int KNOB_WIDTH  = main_config::KNOB_WIDTH,
    parameter int PHASE_WIDTH = main_config::TREM_PHASE_W,
    parameter int INC_SHIFT   = main_config::TREM_INC_SHIFT
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  advance,
    input  logic [KNOB_WIDTH-1:0] speed,
    output logic [LFO_W-1:0]      tri_val,
    output logic [LFO_W-1:0]      lfo
);

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] phase_inc;

    // Speed 0 still moves, so the slowest setting is one step of 1 << INC_SHIFT.
    assign phase_inc = (PHASE_WIDTH'(speed) + PHASE_WIDTH'(1)) << INC_SHIFT;

    assign tri_val = fold_tri(phase[PHASE_WIDTH-1], phase[PHASE_WIDTH-2 -: LFO_W]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phase <= '0;
            lfo   <= '0;
        end else begin
            if (advance) begin
                phase <= phase + phase_inc;  // wraps modulo 2^PHASE_WIDTH
            end
            lfo <= tri_val;
        end
    end

endmodule

// File: rtl/tremolo_core.sv
// Tremolo: amplitude-modulates the sample stream with a triangle LFO.
// Latency: 2 cycles from sample_valid_i to sample_valid_o (gain stage, product stage).
// Backpressure: none; accepts a sample every cycle, output order preserved.
// Ports: clk_i/rstn_i plain; bus (slave) carries samples, knobs, bypass and lfo_o.
module tremolo_core
    import tremolo_core_pkg::*;
#(
    parameter int DATA_WIDTH  = main_config::DATA_WIDTH,
    parameter int KNOB_WIDTH  = main_config::KNOB_WIDTH,
    parameter int PHASE_WIDTH = main_config::TREM_PHASE_W
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    tremolo_core_if.slave  bus
);

    localparam int PROD_W = DATA_WIDTH + 10;

    logic [LFO_W-1:0] tri_val;
    logic [LFO_W-1:0] lfo_q;

    // The LFO advances on the same edge that stage 1 captures the gain, so the
    // gain sees the phase from before this sample's increment.
    trem_lfo #(
        .KNOB_WIDTH  (KNOB_WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_trem_lfo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .advance (bus.sample_valid_i),
        .speed   (bus.speed_i),
        .tri_val (tri_val),
        .lfo     (lfo_q)
    );

    assign bus.lfo_o = lfo_q;

    // Stage 1: sample and gain.
    logic                         s1_vld;
    logic signed [DATA_WIDTH-1:0] s1_sample;
    logic        [GAIN_W-1:0]     s1_gain;
    logic        [GAIN_W-1:0]     gain_nxt;

    assign gain_nxt = calc_gain(LFO_W'(bus.depth_i), tri_val, bus.bypass_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_vld    <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= '0;
        end else begin
            s1_vld <= bus.sample_valid_i;
            if (bus.sample_valid_i) begin
                s1_sample <= bus.sample_i;
                s1_gain   <= gain_nxt;
            end
        end
    end

    // Stage 2: signed multiply by a non-negative gain, then floor-divide by 256.
    // Gain never exceeds 256, so the result always fits DATA_WIDTH and unity
    // gain reproduces the input exactly.
    logic signed [PROD_W-1:0]     product;
    logic                         out_vld;
    logic signed [DATA_WIDTH-1:0] out_q;

    assign product = PROD_W'(s1_sample) * PROD_W'($signed({1'b0, s1_gain}));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_q <= DATA_WIDTH'(product >>> 8);
            end
        end
    end

    assign bus.sample_valid_o = out_vld;
    assign bus.sample_o       = out_q;

endmodule

// File: tb/tb_tremolo_core.sv
module tb_tremolo_core;

    localparam int DW = 24;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    tremolo_core_if #(.DATA_WIDTH(DW), .KNOB_WIDTH(KW)) bus ();

    tremolo_core #(
        .DATA_WIDTH  (DW),
        .KNOB_WIDTH  (KW),
        .PHASE_WIDTH (24)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    typedef struct {
        int         due;
        logic [23:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    longint      phase_m;
    logic [23:0] hold_m;

    // Triangle from the phase: 8-bit segment below the MSB, mirrored in the upper half.
    function automatic int tri_of(input longint ph);
        int seg;
        seg = int'((ph / 32768) % 256);
        return (ph >= 64'd8388608) ? 255 - seg : seg;
    endfunction

    // floor(sample * gain / 256), kept to 24 bits.
    function automatic logic [23:0] scale(input logic [23:0] s, input int gain);
        longint x;
        longint q;
        x = longint'($signed(s)) * gain;
        q = x / 256;
        if (x < 0 && (x % 256) != 0) q = q - 1;
        return q[23:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic watch();
        logic want_vld;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        want_vld = (exp_q.size() > 0 && exp_q[0].due == cyc);
        check("valid_o", {31'd0, bus.sample_valid_o}, {31'd0, want_vld});
        if (want_vld) begin
            hold_m = exp_q[0].val;
            void'(exp_q.pop_front());
        end
        check("sample_o", {8'd0, bus.sample_o}, {8'd0, hold_m});
    endtask

    task automatic tick(input logic v, input logic [23:0] s, input logic [7:0] spd,
                        input logic [7:0] dep, input logic byp);
        int gain;
        bus.sample_valid_i = v;
        bus.sample_i       = s;
        bus.speed_i        = spd;
        bus.depth_i        = dep;
        bus.bypass_i       = byp;
        if (v && rstn) begin
            gain = byp ? 256 : 256 - (int'(dep) * tri_of(phase_m)) / 256;
            exp_q.push_back('{cyc + 2, scale(s, gain)});
            phase_m = (phase_m + (longint'(spd) + 1) * 16) % 64'd16777216;
        end
        @(negedge clk);
        watch();
        if (!rstn) check("lfo_rst", {24'd0, bus.lfo_o}, 32'd0);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 24'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q.delete();
        phase_m = 0;
        hold_m  = 24'd0;
        idle(3);
        rstn = 1'b1;
    endtask

    task automatic check_lfo(input string tag);
        idle(2);
        check(tag, {24'd0, bus.lfo_o}, 32'(tri_of(phase_m)));
    endtask

    initial begin
        logic [23:0] s;
        logic        v;

        rstn               = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
        bus.speed_i        = '0;
        bus.depth_i        = '0;
        bus.bypass_i       = 1'b0;
        phase_m            = 0;
        hold_m             = 24'd0;
        @(posedge clk);
        #1;
        do_reset();
        check_lfo("lfo_after_reset");

        // Zero depth: output equals input, sparse samples.
        repeat (3) begin
            tick(1'b1, 24'h400000, 8'($urandom()), 8'd0, 1'b0);
            idle(1000);
            check("depth0_hold", {8'd0, bus.sample_o}, 32'h00400000);
        end

        // Full speed, full depth: half a cycle lands on the triangle peak.
        do_reset();
        tick(1'b1, 24'h7FFFFF, 8'd255, 8'd255, 1'b0);  // first sample after reset: unity gain
        repeat (2047) tick(1'b1, 24'h400000, 8'd255, 8'd255, 1'b0);
        check_lfo("lfo_peak_model");
        check("lfo_peak", {24'd0, bus.lfo_o}, 32'd255);
        tick(1'b1, 24'h400000, 8'd255, 8'd255, 1'b0);
        idle(3);
        check("peak_pos", {8'd0, bus.sample_o}, 32'h00008000);
        tick(1'b1, 24'hC00000, 8'd255, 8'd255, 1'b0);
        idle(3);
        check("peak_neg", {8'd0, bus.sample_o}, 32'h00FF8000);

        // Complete the cycle: 4096 samples in total wrap the phase to zero.
        repeat (2046) tick(1'b1, 24'($urandom()), 8'd255, 8'd255, 1'b0);
        check_lfo("lfo_wrap_model");
        check("lfo_wrap", {24'd0, bus.lfo_o}, 32'd0);
        s = 24'($urandom());
        tick(1'b1, s, 8'd255, 8'd255, 1'b0);
        idle(3);
        check("wrap_unity", {8'd0, bus.sample_o}, {8'd0, s});

        // Bypass at the triangle peak: eight back-to-back samples pass unchanged.
        do_reset();
        repeat (2048) tick(1'b1, 24'($urandom()), 8'd255, 8'd255, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 24'($urandom()), 8'd255, 8'd255, 1'b1);
        end
        s = 24'($urandom());
        tick(1'b1, s, 8'd255, 8'd255, 1'b1);
        idle(3);
        check("bypass_last", {8'd0, bus.sample_o}, {8'd0, s});
        check_lfo("lfo_after_bypass");

        // Random traffic: gaps, bursts, knobs and bypass all varying.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            tick(v, 24'($urandom()), 8'($urandom()), 8'($urandom()),
                 ($urandom_range(0, 7) == 0));
            if (i % 250 == 249) check_lfo("lfo_random");
        end
        idle(3);

        // Reset right behind a sample: that sample must never come out.
        tick(1'b1, 24'h123456, 8'd10, 8'd100, 1'b0);
        do_reset();
        idle(4);
        check_lfo("lfo_after_flush");
        s = 24'($urandom());
        tick(1'b1, s, 8'd200, 8'd255, 1'b0);
        idle(3);
        check("first_after_reset", {8'd0, bus.sample_o}, {8'd0, s});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
